// File: rtl/alu_pkg.sv
// Shared types, default latencies and result helper for the four-bank ALU packet interface.
// Combinational helper only; no timing or flow control lives here.
package alu_pkg;

  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_ADD_LAT   = 2;
  localparam int DEF_MUL_LAT   = 4;

  typedef enum logic [1:0] {
    NOP      = 2'd0,
    ADD      = 2'd1,
    MULTIPLY = 2'd2,
    AND      = 2'd3
  } command_names_t;

  // Encoding 3 is reserved and never driven.
  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2
  } response_names_t;

  typedef struct packed {
    command_names_t command;
    logic [31:0]    data1;
    logic [31:0]    data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t response;
    logic [31:0]     data;
  } output_packet_t;

  function automatic output_packet_t compute_result(input input_packet_t op);
    output_packet_t res;
    logic [32:0]    sum;
    logic [63:0]    prod;
    sum  = {1'b0, op.data1} + {1'b0, op.data2};
    prod = 64'(op.data1) * 64'(op.data2);
    res  = '{response: NO_RESPONSE, data: 32'd0};
    case (op.command)
      ADD:      res = '{response: sum[32] ? OVERFLOW : SUCCESS, data: sum[31:0]};
      MULTIPLY: res = '{response: (prod[63:32] != 32'd0) ? OVERFLOW : SUCCESS, data: prod[31:0]};
      AND:      res = '{response: SUCCESS, data: op.data1 & op.data2};
      default:  res = '{response: NO_RESPONSE, data: 32'd0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_bank.sv
// One ALU bank: capture command, count down ADD_LAT/MUL_LAT edges, present a one-cycle response.
// No backpressure; commands arriving while busy are dropped, a command on the respond-exit edge is taken.
module alu_bank
  import alu_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic           clock,
  input  logic           reset,
  input  input_packet_t  input_packet,
  output output_packet_t output_packet,
  output logic           busy
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  input_packet_t  op_q, op_d;
  output_packet_t out_q, out_d;
  logic           capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;
    capture = 1'b0;
    case (state_q)
      IDLE: capture = (input_packet.command != NOP);
      EXEC: begin
        if (cnt_q == '0) begin
          out_d   = compute_result(op_q);
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        out_d   = '{response: NO_RESPONSE, data: 32'd0};
        state_d = IDLE;
        capture = (input_packet.command != NOP);
      end
      default: state_d = IDLE;
    endcase
    // Countdown is loaded with latency-1 so the response lands exactly L edges after capture.
    if (capture) begin
      op_d    = input_packet;
      cnt_d   = (input_packet.command == MULTIPLY) ? CNT_W'(MUL_LAT - 1) : CNT_W'(ADD_LAT - 1);
      state_d = EXEC;
    end
  end

  assign output_packet = out_q;
  assign busy          = (state_q == EXEC);

endmodule

// File: rtl/alu_bank_responder.sv
// Responder for NUM_BANKS independent ALU banks; ADD/AND respond ADD_LAT edges after capture, MULTIPLY MUL_LAT.
// No backpressure; each bank drops commands while busy and accepts back-to-back on its respond-exit edge.
module alu_bank_responder
  import alu_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADD_LAT   = DEF_ADD_LAT,
  parameter int MUL_LAT   = DEF_MUL_LAT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  input_packet_t  [NUM_BANKS-1:0]  input_packet,
  output output_packet_t [NUM_BANKS-1:0]  output_packet,
  output logic           [NUM_BANKS-1:0]  busy
);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    alu_bank #(
      .ADD_LAT (ADD_LAT),
      .MUL_LAT (MUL_LAT)
    ) u_bank (
      .clock         (clock),
      .reset         (reset),
      .input_packet  (input_packet[b]),
      .output_packet (output_packet[b]),
      .busy          (busy[b])
    );
  end

endmodule
